// File: rtl/test_pattern_checker_if.sv
// Ethernet header + AXI-Stream payload bundle for the test-pattern receive path.
// Master drives header/beat fields and valids; slave returns the two readies.
interface test_pattern_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  s_eth_hdr_valid;
  logic                  s_eth_hdr_ready;
  logic [47:0]           s_eth_dest_mac;
  logic [47:0]           s_eth_src_mac;
  logic [15:0]           s_eth_type;
  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata;
  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep;
  logic                  s_eth_payload_axis_tvalid;
  logic                  s_eth_payload_axis_tready;
  logic                  s_eth_payload_axis_tlast;
  logic                  s_eth_payload_axis_tuser;

  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    output s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep,
    output s_eth_payload_axis_tvalid, s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready
  );

  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    input  s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep,
    input  s_eth_payload_axis_tvalid, s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready
  );
endinterface

// File: rtl/test_pattern_checker.sv
// Receive-side test-pattern checker: header, payload pattern, length, index sequence and latency stats.
// Stats update 2 cycles after tlast accept; hdr_ready only in IDLE, tready only in PAYLOAD, one DONE bubble per frame.
module test_pattern_checker #(
  parameter int          DATA_LENGTH = 64,
  parameter int          DATA_WIDTH  = 8,
  parameter int          KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter logic [15:0] GAP_LIMIT   = 16'h0FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [47:0] src_mac,
  input  logic [47:0] dst_mac,
  input  logic [15:0] timestamp,
  test_pattern_checker_if.slave rx,
  output logic        error,
  output logic [31:0] pkt_count,
  output logic [31:0] err_pkt_count,
  output logic [31:0] seq_err_count,
  output logic [31:0] lost_count,
  output logic [15:0] gap_overflow_count,
  output logic [15:0] last_time_gap,
  output logic [15:0] min_time_gap,
  output logic [15:0] max_time_gap
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DONE} state_t;

  function automatic logic [31:0] inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [15:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {17'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  state_t          state;
  logic            hdr_ready_q;
  logic            tready_q;
  logic            hdr_err;
  logic            data_err;
  logic            len_err;
  logic            usr_err;
  logic [15:0]     byte_cnt;
  logic [3:0][7:0] cap_q;
  logic [3:0]      cap_vld;

  logic            hdr_fire;
  logic            beat;
  logic [3:0][7:0] cap_d;
  logic [3:0]      cap_vld_d;
  logic [31:0]     lane_k;
  logic [7:0]      lane_byte;
  logic [16:0]     keep_sum;
  logic [16:0]     cnt_sum;
  logic [15:0]     byte_cnt_d;
  logic            beat_data_err;
  logic            beat_len_err;

  assign rx.s_eth_hdr_ready           = hdr_ready_q;
  assign rx.s_eth_payload_axis_tready = tready_q;

  assign hdr_fire = (state == IDLE) && rx.s_eth_hdr_valid && hdr_ready_q;
  assign beat     = (state == PAYLOAD) && rx.s_eth_payload_axis_tvalid && tready_q;

  // Byte 0 captured in this same beat must already drive the pattern compare,
  // hence the two passes over the lanes.
  always_comb begin
    cap_d         = cap_q;
    cap_vld_d     = cap_vld;
    keep_sum      = '0;
    lane_k        = '0;
    lane_byte     = '0;
    beat_data_err = 1'b0;
    beat_len_err  = 1'b0;
    for (int l = 0; l < KEEP_WIDTH; l++) begin
      if (rx.s_eth_payload_axis_tkeep[l]) begin
        lane_k   = 32'(byte_cnt) + 32'(l);
        keep_sum = keep_sum + 17'd1;
        if (lane_k < 32'd4) begin
          cap_d[lane_k[1:0]]     = rx.s_eth_payload_axis_tdata[8*l +: 8];
          cap_vld_d[lane_k[1:0]] = 1'b1;
        end
      end
    end
    for (int l = 0; l < KEEP_WIDTH; l++) begin
      if (rx.s_eth_payload_axis_tkeep[l]) begin
        lane_k    = 32'(byte_cnt) + 32'(l);
        lane_byte = rx.s_eth_payload_axis_tdata[8*l +: 8];
        if (lane_k >= 32'(DATA_LENGTH)) begin
          beat_len_err = 1'b1;
        end else if (lane_k >= 32'd4 && lane_byte != 8'(lane_k[7:0] + cap_d[0])) begin
          beat_data_err = 1'b1;
        end
      end
    end
    cnt_sum    = {1'b0, byte_cnt} + keep_sum;
    byte_cnt_d = cnt_sum[16] ? '1 : cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hdr_ready_q <= 1'b0;
      tready_q    <= 1'b0;
      hdr_err     <= 1'b0;
      data_err    <= 1'b0;
      len_err     <= 1'b0;
      usr_err     <= 1'b0;
      byte_cnt    <= '0;
      cap_q       <= '0;
      cap_vld     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_fire) begin
            state       <= PAYLOAD;
            hdr_ready_q <= 1'b0;
            tready_q    <= 1'b1;
            hdr_err     <= (rx.s_eth_dest_mac != dst_mac) ||
                           (rx.s_eth_src_mac != src_mac) ||
                           (rx.s_eth_type != ETH_TYPE);
            data_err    <= 1'b0;
            len_err     <= 1'b0;
            usr_err     <= 1'b0;
            byte_cnt    <= '0;
            cap_q       <= '0;
            cap_vld     <= '0;
          end else begin
            hdr_ready_q <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (beat) begin
            byte_cnt <= byte_cnt_d;
            cap_q    <= cap_d;
            cap_vld  <= cap_vld_d;
            data_err <= data_err | beat_data_err;
            if (rx.s_eth_payload_axis_tlast) begin
              len_err  <= len_err | beat_len_err | (byte_cnt_d != 16'(DATA_LENGTH));
              usr_err  <= rx.s_eth_payload_axis_tuser;
              state    <= DONE;
              tready_q <= 1'b0;
            end else begin
              len_err <= len_err | beat_len_err;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          hdr_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          hdr_ready_q <= 1'b0;
          tready_q    <= 1'b0;
        end
      endcase
    end
  end

  logic        done;
  logic        bad;
  logic [15:0] rx_idx;
  logic [15:0] rx_ts;
  logic [15:0] gap;
  logic [15:0] seq_d;
  logic [15:0] exp_idx;
  logic        seeded;

  logic        error_n;
  logic [31:0] pkt_n, err_n, seq_n, lost_n;
  logic [15:0] ovf_n, last_n, min_n, max_n, exp_n;
  logic        seeded_n;

  assign done   = (state == DONE);
  assign bad    = hdr_err | data_err | len_err | usr_err;
  assign rx_idx = {cap_q[1], cap_q[0]};
  assign rx_ts  = {cap_q[3], cap_q[2]};
  assign gap    = timestamp - rx_ts;
  assign seq_d  = rx_idx - exp_idx;

  // Clear builds the base, so a DONE in the same cycle still lands on top of it.
  always_comb begin
    pkt_n    = clear ? '0 : pkt_count;
    err_n    = clear ? '0 : err_pkt_count;
    seq_n    = clear ? '0 : seq_err_count;
    lost_n   = clear ? '0 : lost_count;
    ovf_n    = clear ? '0 : gap_overflow_count;
    last_n   = clear ? '0 : last_time_gap;
    max_n    = clear ? '0 : max_time_gap;
    min_n    = clear ? 16'hFFFF : min_time_gap;
    error_n  = clear ? 1'b0 : error;
    seeded_n = clear ? 1'b0 : seeded;
    exp_n    = exp_idx;
    if (done) begin
      pkt_n = inc32(pkt_n);
      if (bad) begin
        err_n   = inc32(err_n);
        error_n = 1'b1;
      end
      if (&cap_vld[1:0]) begin
        if (seeded_n && rx_idx != exp_idx) begin
          seq_n = inc32(seq_n);
          if (!seq_d[15]) lost_n = add32(lost_n, seq_d);
        end
        seeded_n = 1'b1;
        exp_n    = rx_idx + 16'd1;
      end
      if (&cap_vld && !usr_err) begin
        if (gap < GAP_LIMIT) begin
          last_n = gap;
          if (gap > max_n) max_n = gap;
          if (gap < min_n) min_n = gap;
        end else begin
          ovf_n = inc16(ovf_n);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error              <= 1'b0;
      pkt_count          <= '0;
      err_pkt_count      <= '0;
      seq_err_count      <= '0;
      lost_count         <= '0;
      gap_overflow_count <= '0;
      last_time_gap      <= '0;
      max_time_gap       <= '0;
      min_time_gap       <= 16'hFFFF;
      seeded             <= 1'b0;
      exp_idx            <= '0;
    end else begin
      error              <= error_n;
      pkt_count          <= pkt_n;
      err_pkt_count      <= err_n;
      seq_err_count      <= seq_n;
      lost_count         <= lost_n;
      gap_overflow_count <= ovf_n;
      last_time_gap      <= last_n;
      max_time_gap       <= max_n;
      min_time_gap       <= min_n;
      seeded             <= seeded_n;
      exp_idx            <= exp_n;
    end
  end

endmodule
